// File: rtl/fft_dly_pkg.sv
// Shared constants, storage entry type and pointer-width helper for the FFT delay line.
package fft_dly_pkg;

    localparam int FFT_DLY_W_DEF    = 16;
    localparam int FFT_DLY_MAXD_DEF = 64;

    // One storage slot at the default word width: valid flag above the data word.
    typedef struct packed {
        logic                     vld;
        logic [FFT_DLY_W_DEF-1:0] data;
    } fft_dly_entry_t;

    function automatic int ptr_w(input int maxd);
        return (maxd > 1) ? $clog2(maxd) : 1;
    endfunction

endpackage

// File: rtl/fft_dly_ram.sv
// Simple dual-port storage: synchronous write, combinational read, no reset.
module fft_dly_ram #(
    parameter int W     = 17,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_dly_line.sv
// Run-time programmable W-bit delay line with valid tracking, stall, flush and fill count.
// FFT_DLY_RANGE_CHK_EN: clamp out-of-range delay loads and raise a sticky err flag.
module fft_dly_line
    import fft_dly_pkg::*;
#(
    parameter int W    = FFT_DLY_W_DEF,
    parameter int MAXD = FFT_DLY_MAXD_DEF,
    parameter int DLY0 = MAXD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  dly_ld,
    input  logic [$clog2(MAXD):0] dly,
    input  logic [W-1:0]          din,
    input  logic                  din_vld,
    output logic [W-1:0]          dout,
    output logic                  dout_vld,
    output logic [$clog2(MAXD):0] dly_cur,
    output logic                  err
);

    localparam int PW = ptr_w(MAXD);
    localparam int CW = $clog2(MAXD) + 1;
    localparam logic [PW-1:0] WP_LAST = PW'(MAXD - 1);
    localparam logic [CW-1:0] MAXD_C  = CW'(MAXD);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dly_cur_q, dly_cur_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          err_q, err_d;

    logic [CW-1:0] rd_off, wp_ext, rp_ext, dly_sel;
    logic [PW-1:0] rd_addr;
    logic [W:0]    rd_entry;
    logic          we, dly_bad;

`ifdef FFT_DLY_RANGE_CHK_EN
    always_comb begin
        dly_sel = dly;
        dly_bad = 1'b0;
        if (dly == '0) begin
            dly_sel = ONE_C;
            dly_bad = 1'b1;
        end else if (dly > MAXD_C) begin
            dly_sel = MAXD_C;
            dly_bad = 1'b1;
        end
    end
`else
    assign dly_sel = dly;
    assign dly_bad = 1'b0;
`endif

    // Read slot is dly_cur-1 writes behind wp; wrap by adding MAXD since MAXD may not be 2^n.
    always_comb begin
        rd_off = dly_cur_q - ONE_C;
        wp_ext = CW'(wp_q);
        if (wp_ext >= rd_off) begin
            rp_ext = wp_ext - rd_off;
        end else begin
            rp_ext = wp_ext + MAXD_C - rd_off;
        end
        rd_addr = rp_ext[PW-1:0];
    end

    fft_dly_ram #(
        .W     (W + 1),
        .DEPTH (MAXD),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp_q),
        .wdata ({din_vld, din}),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    always_comb begin
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        dly_cur_d  = dly_cur_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        err_d      = err_q;
        we         = 1'b0;
        if (dly_ld) begin
            dly_cur_d  = dly_sel;
            cnt_d      = '0;
            dout_vld_d = 1'b0;
            err_d      = err_q | dly_bad;
        end else if (flush) begin
            cnt_d      = '0;
            dout_vld_d = 1'b0;
        end else if (en) begin
            we   = 1'b1;
            wp_d = (wp_q == WP_LAST) ? '0 : wp_q + PW'(1);
            if (dly_cur_q == ONE_C) begin
                dout_d     = din;
                dout_vld_d = din_vld;
            end else begin
                dout_d     = rd_entry[W-1:0];
                dout_vld_d = rd_entry[W];
            end
            // Slots not yet refilled since the last flush/load hold stale words.
            if (cnt_q + ONE_C < dly_cur_q) begin
                dout_vld_d = 1'b0;
            end
            if (cnt_q != MAXD_C) begin
                cnt_d = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            cnt_q      <= '0;
            dly_cur_q  <= CW'(DLY0);
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            dly_cur_q  <= dly_cur_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            err_q      <= err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign dly_cur  = dly_cur_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fft_dly_line.sv
// Bench for fft_dly_line: two instances (MAXD=64 and MAXD=48) share stimulus and are
// compared against a write-history reference model.
module tb_fft_dly_line;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        dly_ld;
    logic [6:0]  dly;
    logic [15:0] din;
    logic        din_vld;

    logic [15:0] dout_a, dout_b;
    logic        vld_a, vld_b;
    logic [6:0]  dly_cur_a, dly_cur_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    fft_dly_line #(.W(16), .MAXD(64), .DLY0(64)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .dly_ld   (dly_ld),
        .dly      (dly),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout_a),
        .dout_vld (vld_a),
        .dly_cur  (dly_cur_a),
        .err      (err_a)
    );

    fft_dly_line #(.W(16), .MAXD(48), .DLY0(48)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .dly_ld   (dly_ld),
        .dly      (dly),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout_b),
        .dout_vld (vld_b),
        .dly_cur  (dly_cur_b),
        .err      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: output is the word written d-1 writes before the current one,
    // valid once d writes have happened since the last flush/load.
    int          maxd [2] = '{64, 48};
    int          d [2];
    int          fill;
    logic [15:0] exp_dout [2];
    logic        exp_vld [2];
    logic        exp_err [2];
    bit          known [2];
    logic [16:0] hist [$];

    function automatic int clamp_dly(input int v, input int m);
`ifdef FFT_DLY_RANGE_CHK_EN
        if (v == 0) return 1;
        if (v > m) return m;
`endif
        return v;
    endfunction

    function automatic bit out_of_range(input int v, input int m);
`ifdef FFT_DLY_RANGE_CHK_EN
        return (v == 0) || (v > m);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        fill = 0;
        for (int i = 0; i < 2; i++) begin
            d[i]        = maxd[i];
            exp_dout[i] = 16'h0;
            exp_vld[i]  = 1'b0;
            exp_err[i]  = 1'b0;
            known[i]    = 1'b1;
        end
    endtask

    task automatic model_edge();
        logic [16:0] e;
        if (dly_ld) begin
            fill = 0;
            for (int i = 0; i < 2; i++) begin
                d[i] = clamp_dly(int'(dly), maxd[i]);
                if (out_of_range(int'(dly), maxd[i])) exp_err[i] = 1'b1;
                exp_vld[i] = 1'b0;
            end
        end else if (flush) begin
            fill = 0;
            exp_vld[0] = 1'b0;
            exp_vld[1] = 1'b0;
        end else if (en) begin
            hist.push_back({din_vld, din});
            if (hist.size() > 64) void'(hist.pop_front());
            fill++;
            for (int i = 0; i < 2; i++) begin
                if (hist.size() >= d[i]) begin
                    e           = hist[hist.size() - d[i]];
                    exp_dout[i] = e[15:0];
                    known[i]    = 1'b1;
                    exp_vld[i]  = (fill >= d[i]) ? e[16] : 1'b0;
                end else begin
                    known[i]   = 1'b0;
                    exp_vld[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic [15:0] o_dout,
                              input logic o_vld, input logic [6:0] o_dc, input logic o_err);
        check({nm, "_vld"}, 32'(o_vld), 32'(exp_vld[i]));
        check({nm, "_dly_cur"}, 32'(o_dc), 32'(d[i]));
        check({nm, "_err"}, 32'(o_err), 32'(exp_err[i]));
        if (known[i]) check({nm, "_dout"}, 32'(o_dout), 32'(exp_dout[i]));
    endtask

    task automatic check_all();
        check_inst(0, "a", dout_a, vld_a, dly_cur_a, err_a);
        check_inst(1, "b", dout_b, vld_b, dly_cur_b, err_b);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic i_en, input logic i_fl, input logic i_ld,
                         input logic [6:0] i_dly, input logic [15:0] i_din, input logic i_vld);
        en      = i_en;
        flush   = i_fl;
        dly_ld  = i_ld;
        dly     = i_dly;
        din     = i_din;
        din_vld = i_vld;
    endtask

    task automatic load_dly(input logic [6:0] v);
        drive(1'b1, 1'b0, 1'b1, v, 16'hDEAD, 1'b1);
        step();
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, 1'b0);
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Power-on delay: ramp with valid, first output after edge DLY0.
        for (int i = 1; i <= 70; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(i), 1'b1);
            step();
        end

        // Bypass path.
        load_dly(7'd1);
        drive(1'b1, 1'b0, 1'b0, 7'd0, 16'hA5A5, 1'b1);
        step();

        // Stalls do not count toward the delay.
        load_dly(7'd5);
        for (int i = 0; i < 30; i++) begin
            drive((i % 2) == 0, 1'b0, 1'b0, 7'd0, 16'(16'h100 + i), 1'b1);
            step();
        end

        // Flush mid-stream, then flush together with a load.
        load_dly(7'd8);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h200 + i), 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 7'd0, 16'hBEEF, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h300 + i), 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 7'd3, 16'hCAFE, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h400 + i), 1'b1);
            step();
        end

        // Randomised mix of stalls, flushes, loads and sparse valids.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 59) == 0), 7'($urandom_range(1, 48)),
                  16'($urandom), ($urandom_range(0, 4) != 0));
            step();
        end

        // Full-depth delay across many pointer wraps.
        load_dly(7'd48);
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h1000 + i), 1'b1);
            step();
        end

`ifdef FFT_DLY_RANGE_CHK_EN
        load_dly(7'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h2000 + i), 1'b1);
            step();
        end
        load_dly(7'd100);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h2100 + i), 1'b1);
            step();
        end
`endif

        // Asynchronous reset in the middle of traffic.
        load_dly(7'd4);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h3000 + i), 1'b1);
            step();
        end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 7'd0, 16'(16'h4000 + i), 1'b1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
